// File: rtl/mem_pkg.sv
// Shared types and constants for the shadow main-memory arbiter.
package mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic DIR_WRITE = 1'b0;
  localparam logic DIR_READ  = 1'b1;

  localparam logic [ADDR_W-1:0] ROM_TOP_DEFAULT = 16'h7FFF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/mem_arb_select.sv
// CPU-priority arbiter with a DMA starvation limit; yields the winner and the next burst count.
module mem_arb_select
  import mem_pkg::*;
#(
  parameter int unsigned CPU_BURST_MAX = 4
) (
  input  logic             i_cpu_req,
  input  logic             i_dma_req,
  input  logic             i_grant_en,
  input  logic [CNT_W-1:0] i_burst_cnt,
  output logic             o_grant,
  output logic             o_sel_dma,
  output logic [CNT_W-1:0] o_burst_cnt
);

  logic w_at_limit;

  assign w_at_limit = (i_burst_cnt == CNT_W'(CPU_BURST_MAX));
  assign o_grant    = i_grant_en && (i_cpu_req || i_dma_req);
  assign o_sel_dma  = i_dma_req && (!i_cpu_req || w_at_limit);

  // Count only CPU grants made while DMA is waiting.
  always_comb begin
    o_burst_cnt = i_burst_cnt;
    if (!i_dma_req || (o_grant && o_sel_dma)) begin
      o_burst_cnt = '0;
    end else if (o_grant) begin
      o_burst_cnt = i_burst_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Sequences the 64K shadow memory for the CPU and DMA ports (SETUP/STROBE/CAPTURE/DONE).
// Define MEMARB_ROM_WRITE_PROTECT_EN to suppress the strobe for writes at or below ROM_TOP.
module mem_bus_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned       CPU_BURST_MAX = 4,
  parameter logic [ADDR_W-1:0] ROM_TOP       = ROM_TOP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              MemBridge_Load,
  output logic              MemBridge_Direction,
  output logic              Memory_Ack,
  output logic              busy,
  output logic              wp_err
);

`ifdef MEMARB_ROM_WRITE_PROTECT_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif

  state_t            r_state;
  logic              r_sel_dma;
  logic              r_we;
  logic [CNT_W-1:0]  r_burst_cnt;

  logic              w_grant;
  logic              w_sel_dma;
  logic [CNT_W-1:0]  w_burst_cnt;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_wp_block;

  mem_arb_select #(
    .CPU_BURST_MAX(CPU_BURST_MAX)
  ) u_select (
    .i_cpu_req  (cpu_req),
    .i_dma_req  (dma_req),
    .i_grant_en ((r_state == IDLE) || (r_state == DONE)),
    .i_burst_cnt(r_burst_cnt),
    .o_grant    (w_grant),
    .o_sel_dma  (w_sel_dma),
    .o_burst_cnt(w_burst_cnt)
  );

  assign w_win_we    = w_sel_dma ? dma_we    : cpu_we;
  assign w_win_addr  = w_sel_dma ? dma_addr  : cpu_addr;
  assign w_win_wdata = w_sel_dma ? dma_wdata : cpu_wdata;

  assign w_wp_block  = WP_EN && r_we && (Addr <= ROM_TOP);
  assign busy        = (r_state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state             <= IDLE;
      r_sel_dma           <= 1'b0;
      r_we                <= 1'b0;
      r_burst_cnt         <= '0;
      Addr                <= '0;
      mem_wdata           <= '0;
      mem_wdata_oe        <= 1'b0;
      MemBridge_Load      <= 1'b1;
      MemBridge_Direction <= DIR_READ;
      Memory_Ack          <= 1'b0;
      cpu_ack             <= 1'b0;
      dma_ack             <= 1'b0;
      cpu_rdata           <= '0;
      dma_rdata           <= '0;
      wp_err              <= 1'b0;
    end else begin
      r_burst_cnt <= w_burst_cnt;
      case (r_state)
        IDLE, DONE: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          wp_err  <= 1'b0;
          if (w_grant) begin
            r_state             <= SETUP;
            r_sel_dma           <= w_sel_dma;
            r_we                <= w_win_we;
            Addr                <= w_win_addr;
            mem_wdata           <= w_win_wdata;
            MemBridge_Direction <= w_win_we ? DIR_WRITE : DIR_READ;
            mem_wdata_oe        <= w_win_we;
          end else begin
            r_state <= IDLE;
          end
        end
        SETUP: begin
          r_state        <= STROBE;
          MemBridge_Load <= w_wp_block;
        end
        STROBE: begin
          r_state        <= CAPTURE;
          MemBridge_Load <= 1'b1;
          Memory_Ack     <= !r_we;
        end
        CAPTURE: begin
          r_state             <= DONE;
          Memory_Ack          <= 1'b0;
          mem_wdata_oe        <= 1'b0;
          MemBridge_Direction <= DIR_READ;
          wp_err              <= w_wp_block;
          if (r_sel_dma) begin
            dma_ack <= 1'b1;
            if (!r_we) dma_rdata <= mem_rdata;
          end else begin
            cpu_ack <= 1'b1;
            if (!r_we) cpu_rdata <= mem_rdata;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: memory model, reference RAM and per-scenario tasks.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int unsigned BURST   = 4;
  localparam logic [15:0] ROM_TOP = 16'h7FFF;
`ifdef MEMARB_ROM_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] cpu_addr = '0, dma_addr = '0;
  logic [7:0]  cpu_wdata = '0, dma_wdata = '0;
  logic        cpu_ack, dma_ack, mem_wdata_oe, MemBridge_Load, MemBridge_Direction;
  logic        Memory_Ack, busy, wp_err;
  logic [7:0]  cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [15:0] Addr;

  int checks = 0;
  int errors = 0;
  int load_falls = 0;

  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_ram [0:65535];
  logic [7:0]  mem_out = 8'h00;
  logic        pend_wr = 1'b0;
  logic [15:0] pend_addr = '0;
  logic [7:0]  pend_data = '0;
  logic [8:1]  obs_load, obs_mack, obs_dir, obs_oe;

  mem_bus_arbiter #(
    .CPU_BURST_MAX(BURST),
    .ROM_TOP      (ROM_TOP)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .cpu_req            (cpu_req),
    .cpu_we             (cpu_we),
    .cpu_addr           (cpu_addr),
    .cpu_wdata          (cpu_wdata),
    .cpu_ack            (cpu_ack),
    .cpu_rdata          (cpu_rdata),
    .dma_req            (dma_req),
    .dma_we             (dma_we),
    .dma_addr           (dma_addr),
    .dma_wdata          (dma_wdata),
    .dma_ack            (dma_ack),
    .dma_rdata          (dma_rdata),
    .Addr               (Addr),
    .mem_wdata          (mem_wdata),
    .mem_wdata_oe       (mem_wdata_oe),
    .mem_rdata          (mem_rdata),
    .MemBridge_Load     (MemBridge_Load),
    .MemBridge_Direction(MemBridge_Direction),
    .Memory_Ack         (Memory_Ack),
    .busy               (busy),
    .wp_err             (wp_err)
  );

  always #5 clk = ~clk;

  // Memory: falling Load starts the access; a write commits when Load rises outside reset.
  always @(negedge MemBridge_Load) begin
    load_falls++;
    if (MemBridge_Direction == 1'b0) begin
      pend_wr   = 1'b1;
      pend_addr = Addr;
      pend_data = mem_wdata_oe ? mem_wdata : 8'hBD;
    end else begin
      mem_out = ram[Addr];
    end
  end

  always @(posedge MemBridge_Load) begin
    if (pend_wr && reset_n) ram[pend_addr] = pend_data;
    pend_wr = 1'b0;
  end

  assign mem_rdata = Memory_Ack ? mem_out : 8'hEE;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checks++;
      if (mem_wdata_oe && Memory_Ack) begin
        errors++;
        $display("FAIL contention: oe=%b mem_ack=%b, required not both 1", mem_wdata_oe, Memory_Ack);
      end
      checks++;
      if (cpu_ack && dma_ack) begin
        errors++;
        $display("FAIL dual_ack: cpu_ack=%b dma_ack=%b, required not both 1", cpu_ack, dma_ack);
      end
      checks++;
      if (!MemBridge_Load && !busy) begin
        errors++;
        $display("FAIL load_idle: Load=%b busy=%b, Load low only while busy", MemBridge_Load, busy);
      end
    end
  end

  function automatic bit protected_wr(input bit we, input logic [15:0] a);
    return WP && we && (a <= ROM_TOP);
  endfunction

  // One isolated transaction; records per-cycle pin samples and the ack latency.
  task automatic run_single(input bit is_dma, input bit we, input logic [15:0] a,
                            input logic [7:0] d, output int lat, output logic [7:0] rd,
                            output bit wp, output int falls, output bit other,
                            output bit ack_after, output bit busy_after);
    int f0;
    f0 = load_falls;
    lat = 0; rd = '0; wp = 1'b0; other = 1'b0;
    obs_load = '0; obs_mack = '0; obs_dir = '0; obs_oe = '0;
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        obs_load[k] = MemBridge_Load;
        obs_mack[k] = Memory_Ack;
        obs_dir[k]  = MemBridge_Direction;
        obs_oe[k]   = mem_wdata_oe;
      end
      if (is_dma ? cpu_ack : dma_ack) other = 1'b1;
      if (is_dma ? dma_ack : cpu_ack) begin
        lat = k;
        rd  = is_dma ? dma_rdata : cpu_rdata;
        wp  = wp_err;
        break;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    cpu_addr = 16'($urandom); dma_addr = 16'($urandom);
    @(negedge clk);
    ack_after  = is_dma ? dma_ack : cpu_ack;
    busy_after = busy;
    falls = load_falls - f0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({MemBridge_Load, MemBridge_Direction, Memory_Ack, mem_wdata_oe, busy, wp_err, cpu_ack,
         dma_ack} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 11000000", {MemBridge_Load, MemBridge_Direction,
               Memory_Ack, mem_wdata_oe, busy, wp_err, cpu_ack, dma_ack});
    end
    checks++;
    if ({Addr, mem_wdata, cpu_rdata, dma_rdata} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", {Addr, mem_wdata, cpu_rdata, dma_rdata});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || MemBridge_Load !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b Load=%b required 0/1", busy, MemBridge_Load);
    end
  endtask

  task automatic test_cpu_read();
    int lat, falls; logic [7:0] rd; bit wp, oth, aa, ba;
    ram[16'h8000] = 8'h5A; ref_ram[16'h8000] = 8'h5A;
    run_single(1'b0, 1'b0, 16'h8000, 8'h00, lat, rd, wp, falls, oth, aa, ba);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d required 4", lat); end
    checks++;
    if (rd !== 8'h5A) begin errors++; $display("FAIL rd_data: got %h required 5a", rd); end
    checks++;
    if (obs_load[4:1] !== 4'b1101) begin
      errors++; $display("FAIL rd_load_seq: got %b required 1101", obs_load[4:1]);
    end
    checks++;
    if (obs_mack[4:1] !== 4'b0100) begin
      errors++; $display("FAIL rd_memack_seq: got %b required 0100", obs_mack[4:1]);
    end
    checks++;
    if (obs_dir[4:1] !== 4'b1111 || obs_oe[4:1] !== 4'b0000) begin
      errors++; $display("FAIL rd_dir_oe: dir=%b oe=%b required 1111/0000", obs_dir[4:1], obs_oe[4:1]);
    end
    checks++;
    if (aa !== 1'b0 || ba !== 1'b0 || cpu_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL rd_after_ack: ack=%b busy=%b rdata=%h required 0/0/5a", aa, ba, cpu_rdata);
    end
    checks++;
    if (falls !== 1) begin errors++; $display("FAIL rd_falls: got %0d required 1", falls); end
  endtask

  task automatic test_write_read();
    int lat, falls; logic [7:0] rd; bit wp, oth, aa, ba;
    run_single(1'b0, 1'b1, 16'h9001, 8'h3C, lat, rd, wp, falls, oth, aa, ba);
    ref_ram[16'h9001] = 8'h3C;
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d required 4", lat); end
    checks++;
    if (obs_dir[4:1] !== 4'b1000 || obs_oe[4:1] !== 4'b0111) begin
      errors++; $display("FAIL wr_dir_oe: dir=%b oe=%b required 1000/0111", obs_dir[4:1], obs_oe[4:1]);
    end
    checks++;
    if (obs_load[4:1] !== 4'b1101 || obs_mack[4:1] !== 4'b0000) begin
      errors++;
      $display("FAIL wr_load_mack: load=%b mack=%b required 1101/0000", obs_load[4:1], obs_mack[4:1]);
    end
    run_single(1'b0, 1'b0, 16'h9001, 8'h00, lat, rd, wp, falls, oth, aa, ba);
    checks++;
    if (rd !== 8'h3C) begin errors++; $display("FAIL wr_readback: got %h required 3c", rd); end
  endtask

  task automatic test_dma_single();
    int lat, falls; logic [7:0] rd, d; logic [15:0] a; bit wp, oth, aa, ba;
    a = 16'h8000 | 16'($urandom);
    d = 8'($urandom);
    run_single(1'b1, 1'b1, a, d, lat, rd, wp, falls, oth, aa, ba);
    ref_ram[a] = d;
    run_single(1'b1, 1'b0, a, 8'h00, lat, rd, wp, falls, oth, aa, ba);
    checks++;
    if (lat !== 4 || rd !== d) begin
      errors++; $display("FAIL dma_rw: lat=%0d data=%h required 4/%h", lat, rd, d);
    end
    checks++;
    if (oth !== 1'b0 || dma_rdata !== d) begin
      errors++; $display("FAIL dma_isolation: cpu_ack_seen=%b rdata=%h required 0/%h", oth, dma_rdata, d);
    end
  endtask

  task automatic test_simultaneous();
    int ct, dt; logic [7:0] cr, dr;
    ct = 0; dt = 0; cr = '0; dr = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hC000;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'hC001;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (cpu_ack && ct == 0) begin ct = k; cr = cpu_rdata; cpu_req = 1'b0; end
      if (dma_ack && dt == 0) begin dt = k; dr = dma_rdata; dma_req = 1'b0; end
      if (ct != 0 && dt != 0) break;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ct !== 4 || dt !== 8) begin
      errors++; $display("FAIL simul_timing: cpu=%0d dma=%0d required 4/8", ct, dt);
    end
    checks++;
    if (cr !== ref_ram[16'hC000] || dr !== ref_ram[16'hC001]) begin
      errors++; $display("FAIL simul_data: cpu=%h dma=%h required %h/%h", cr, dr,
                         ref_ram[16'hC000], ref_ram[16'hC001]);
    end
  endtask

  // Both ports held busy; each ack issues a fresh random transaction on that port.
  task automatic test_burst(input int ngrants);
    int g, last_t; bit exp_dma, is_dma, we; logic [15:0] a; logic [7:0] rd;
    g = 0; last_t = 0;
    cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
    dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int k = 1; k <= ngrants * 4 + 20 && g < ngrants; k++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) begin
        exp_dma = (g % (BURST + 1)) == BURST;
        is_dma  = dma_ack;
        checks++;
        if (is_dma !== exp_dma) begin
          errors++; $display("FAIL burst_order: grant %0d dma=%b required %b", g, is_dma, exp_dma);
        end
        checks++;
        if (k - last_t !== 4) begin
          errors++; $display("FAIL burst_spacing: grant %0d gap=%0d required 4", g, k - last_t);
        end
        we = is_dma ? dma_we : cpu_we;
        a  = is_dma ? dma_addr : cpu_addr;
        rd = is_dma ? dma_rdata : cpu_rdata;
        if (!we) begin
          checks++;
          if (rd !== ref_ram[a]) begin
            errors++; $display("FAIL burst_data: addr %h got %h required %h", a, rd, ref_ram[a]);
          end
        end else if (!protected_wr(we, a)) begin
          ref_ram[a] = is_dma ? dma_wdata : cpu_wdata;
        end
        if (is_dma) begin
          dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
        end else begin
          cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
        end
        last_t = k;
        g++;
        if (g == ngrants) begin cpu_req = 1'b0; dma_req = 1'b0; end
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    checks++;
    if (g !== ngrants) begin errors++; $display("FAIL burst_timeout: got %0d grants required %0d", g, ngrants); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, falls; logic [7:0] rd; bit wp, oth, aa, ba, saw;
    saw = 1'b0;
    ram[16'hA000] = 8'h11; ref_ram[16'hA000] = 8'h11;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hA000; cpu_wdata = 8'hC3;
    repeat (2) @(negedge clk);
    checks++;
    if (MemBridge_Load !== 1'b0) begin
      errors++; $display("FAIL mid_strobe: Load=%b required 0", MemBridge_Load);
    end
    reset_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    checks++;
    if ({MemBridge_Load, MemBridge_Direction, mem_wdata_oe, busy} !== 4'b1100 || Addr !== 16'h0) begin
      errors++; $display("FAIL mid_reset: ctrl=%b addr=%h required 1100/0000",
                         {MemBridge_Load, MemBridge_Direction, mem_wdata_oe, busy}, Addr);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cpu_ack) saw = 1'b1;
      if (k == 1) reset_n = 1'b1;
    end
    checks++;
    if (saw !== 1'b0 || ram[16'hA000] !== 8'h11) begin
      errors++; $display("FAIL mid_abort: ack_seen=%b ram=%h required 0/11", saw, ram[16'hA000]);
    end
    run_single(1'b0, 1'b0, 16'hA000, 8'h00, lat, rd, wp, falls, oth, aa, ba);
    checks++;
    if (lat !== 4 || rd !== 8'h11) begin
      errors++; $display("FAIL mid_recover: lat=%0d data=%h required 4/11", lat, rd);
    end
  endtask

  task automatic test_rom_write();
    int lat, falls; logic [7:0] rd, exp; bit wp, oth, aa, ba;
    ram[16'h1234] = 8'hA5; ref_ram[16'h1234] = 8'hA5;
    run_single(1'b0, 1'b1, 16'h1234, 8'h77, lat, rd, wp, falls, oth, aa, ba);
    checks++;
    if (lat !== 4 || wp !== WP) begin
      errors++; $display("FAIL rom_wr: lat=%0d wp_err=%b required 4/%b", lat, wp, WP);
    end
    checks++;
    if (falls !== (WP ? 0 : 1)) begin
      errors++; $display("FAIL rom_falls: got %0d required %0d", falls, WP ? 0 : 1);
    end
    exp = WP ? 8'hA5 : 8'h77;
    ref_ram[16'h1234] = exp;
    run_single(1'b0, 1'b0, 16'h1234, 8'h00, lat, rd, wp, falls, oth, aa, ba);
    checks++;
    if (rd !== exp || wp !== 1'b0) begin
      errors++; $display("FAIL rom_readback: data=%h wp_err=%b required %h/0", rd, wp, exp);
    end
  endtask

  task automatic test_random(input int n);
    int lat, falls; logic [7:0] rd, d; logic [15:0] a; bit wp, oth, aa, ba, is_dma, we, prot;
    for (int i = 0; i < n; i++) begin
      is_dma = 1'($urandom); we = 1'($urandom); a = 16'($urandom); d = 8'($urandom);
      prot = protected_wr(we, a);
      run_single(is_dma, we, a, d, lat, rd, wp, falls, oth, aa, ba);
      checks++;
      if (lat !== 4 || oth !== 1'b0 || aa !== 1'b0) begin
        errors++; $display("FAIL rand_handshake %0d: lat=%0d other=%b ack_after=%b required 4/0/0",
                           i, lat, oth, aa);
      end
      checks++;
      if (wp !== prot || falls !== (prot ? 0 : 1)) begin
        errors++; $display("FAIL rand_strobe %0d: wp_err=%b falls=%0d required %b/%0d",
                           i, wp, falls, prot, prot ? 0 : 1);
      end
      if (!we) begin
        checks++;
        if (rd !== ref_ram[a]) begin
          errors++; $display("FAIL rand_data %0d: addr %h got %h required %h", i, a, rd, ref_ram[a]);
        end
      end else if (!prot) begin
        ref_ram[a] = d;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'((i * 37) ^ (i >> 8));
      ref_ram[i] = 8'((i * 37) ^ (i >> 8));
    end
    test_reset();
    test_cpu_read();
    test_write_read();
    test_dma_single();
    test_simultaneous();
    test_burst(12);
    test_burst(7);
    test_reset_mid();
    test_rom_write();
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
